// File: rtl/uart_word_loader_if.sv
// Memory write port driven by the UART word loader.
interface uart_word_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_word_loader.sv
// Serial program loader: 8N1 UART receiver feeding a word assembler that
// issues one memory write per completed word with an auto-incrementing
// address. Adds stop-bit framing checks, inter-byte timeout resync and
// address wrap tracking.
module uart_word_loader #(
  parameter int CLKS_PER_BIT  = 87,
  parameter int WORD_BYTES    = 4,
  parameter int ADDR_W        = 10,
  parameter int LITTLE_ENDIAN = 1,
  parameter int TIMEOUT_CLKS  = 87*40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_serial,
  input  logic                start,
  uart_word_loader_if.master  wr_port,
  output logic [ADDR_W:0]     word_count,
  output logic                frame_err,
  output logic                timeout_err,
  output logic                wrapped,
  output logic                busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int DW = 8*WORD_BYTES;
  localparam int KW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [KW-1:0] K_LAST   = KW'(WORD_BYTES - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CLKS - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  logic          rx_meta, rx_sync;
  logic [2:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          byte_valid;
  logic          stop_ok, stop_bad, start_det;

  logic [KW-1:0]     k;
  logic [KW-1:0]     lane;
  logic [DW-1:0]     word, word_next;
  logic [TW-1:0]     tcnt;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;

  assign stop_ok   = (state == ST_STOP) && (bit_cnt == CNT_LAST) &&  rx_sync;
  assign stop_bad  = (state == ST_STOP) && (bit_cnt == CNT_LAST) && !rx_sync;
  assign start_det = (state == ST_IDLE) && !rx_sync;

  // Two-flop synchroniser for the asynchronous RX line (idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  // UART receive FSM: mid-bit sampling, LSB first, stop-bit check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= stop_ok;
      case (state)
        ST_IDLE: begin
          if (!rx_sync) begin
            state   <= ST_START;
            bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (bit_cnt == CNT_HALF) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            state   <= rx_sync ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Merge the received byte into its lane of the partial word.
  always_comb begin
    word_next = word;
    lane      = (LITTLE_ENDIAN != 0) ? k : (K_LAST - k);
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (lane == KW'(i)) word_next[8*i +: 8] = rx_shift;
    end
  end

  // Word assembly, write strobe, address/count tracking, timeout and flags.
  // start outranks everything here, but the RX FSM keeps running so a frame
  // already in flight becomes byte 0 of the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      word        <= '0;
      tcnt        <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      word_count  <= '0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      wrapped     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (start) begin
        k           <= '0;
        word        <= '0;
        tcnt        <= '0;
        wr_addr_q   <= '0;
        word_count  <= '0;
        frame_err   <= 1'b0;
        timeout_err <= 1'b0;
        wrapped     <= 1'b0;
      end else begin
        if (wr_en_q) begin
          wr_addr_q <= wr_addr_q + 1'b1;
          if (wr_addr_q == '1) wrapped <= 1'b1;
          if (word_count != '1) word_count <= word_count + 1'b1;
        end
        if (stop_bad) begin
          frame_err <= 1'b1;
          k         <= '0;
          word      <= '0;
          tcnt      <= '0;
        end else if (byte_valid) begin
          tcnt <= '0;
          word <= word_next;
          if (k == K_LAST) begin
            wr_en_q <= 1'b1;
            k       <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end else if ((k != '0) && (state == ST_IDLE) && !start_det) begin
          if (tcnt == T_LAST) begin
            k           <= '0;
            word        <= '0;
            tcnt        <= '0;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end else begin
          tcnt <= '0;
        end
      end
    end
  end

  assign busy            = (state != ST_IDLE) || (k != '0) || byte_valid;
  assign wr_port.wr_en   = wr_en_q;
  assign wr_port.wr_addr = wr_addr_q;
  assign wr_port.wr_data = word;

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: a little-endian instance with a 2-bit address
// and a big-endian instance with a 10-bit address share one RX line.
module tb_uart_word_loader;

  localparam int CPB = 8;
  localparam int TO  = CPB*40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic start = 1'b0;

  logic [2:0]  cnt_le;
  logic [10:0] cnt_be;
  logic ferr_le, terr_le, wrap_le, busy_le;
  logic ferr_be, terr_be, wrap_be, busy_be;

  uart_word_loader_if #(.ADDR_W(2),  .DATA_W(32)) if_le ();
  uart_word_loader_if #(.ADDR_W(10), .DATA_W(32)) if_be ();

  uart_word_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4), .ADDR_W(2),
                     .LITTLE_ENDIAN(1), .TIMEOUT_CLKS(TO)) dut_le (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx), .start(start), .wr_port(if_le),
    .word_count(cnt_le), .frame_err(ferr_le), .timeout_err(terr_le),
    .wrapped(wrap_le), .busy(busy_le));

  uart_word_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4), .ADDR_W(10),
                     .LITTLE_ENDIAN(0), .TIMEOUT_CLKS(TO)) dut_be (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx), .start(start), .wr_port(if_be),
    .word_count(cnt_be), .frame_err(ferr_be), .timeout_err(terr_be),
    .wrapped(wrap_be), .busy(busy_be));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_le_d[$];
  int unsigned q_le_a[$];
  logic [31:0] q_be_d[$];
  int unsigned q_be_a[$];
  int unsigned addr_le, addr_be, exp_cnt_le, exp_cnt_be;
  logic        exp_wrap_le;
  logic        prev_le = 1'b0;
  logic        prev_be = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    addr_le = 0; addr_be = 0; exp_cnt_le = 0; exp_cnt_be = 0; exp_wrap_le = 1'b0;
  endtask

  // Scoreboard consumer: every strobe must match the oldest pushed word.
  always @(negedge clk) begin
    if (if_le.wr_en) begin
      if (q_le_d.size() == 0) check("le_unexpected_wr", 64'(1), 64'(0));
      else begin
        check("le_data", 64'(if_le.wr_data), 64'(q_le_d.pop_front()));
        check("le_addr", 64'(if_le.wr_addr), 64'(q_le_a.pop_front()));
      end
      if (prev_le) check("le_double_strobe", 64'(1), 64'(0));
    end
    if (if_be.wr_en) begin
      if (q_be_d.size() == 0) check("be_unexpected_wr", 64'(1), 64'(0));
      else begin
        check("be_data", 64'(if_be.wr_data), 64'(q_be_d.pop_front()));
        check("be_addr", 64'(if_be.wr_addr), 64'(q_be_a.pop_front()));
      end
      if (prev_be) check("be_double_strobe", 64'(1), 64'(0));
    end
    prev_le <= if_le.wr_en;
    prev_be <= if_be.wr_en;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    q_le_d.push_back({b3, b2, b1, b0});
    q_le_a.push_back(addr_le);
    q_be_d.push_back({b0, b1, b2, b3});
    q_be_a.push_back(addr_be);
    if (addr_le == 3) exp_wrap_le = 1'b1;
    addr_le = (addr_le + 1) % 4;
    addr_be = (addr_be + 1) % 1024;
    exp_cnt_le = exp_cnt_le + 1;
    exp_cnt_be = exp_cnt_be + 1;
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
    repeat (4) @(negedge clk);
    check("le_count", 64'(cnt_le), 64'(exp_cnt_le));
    check("be_count", 64'(cnt_be), 64'(exp_cnt_be));
    check("le_wrapped", 64'(wrap_le), 64'(exp_wrap_le));
    check("be_busy", 64'(busy_be), 64'(0));
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    model_clear();
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_le_wr_en"}, 64'(if_le.wr_en),   64'(0));
    check({p, "_le_addr"},  64'(if_le.wr_addr), 64'(0));
    check({p, "_le_data"},  64'(if_le.wr_data), 64'(0));
    check({p, "_le_flags"}, 64'({cnt_le, ferr_le, terr_le, wrap_le, busy_le}), 64'(0));
    check({p, "_be_all"},   64'({if_be.wr_en, if_be.wr_addr, cnt_be, ferr_be, terr_be,
                                 wrap_be, busy_be}), 64'(0));
    check({p, "_be_data"},  64'(if_be.wr_data), 64'(0));
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2*CPB) @(negedge clk);

    // Basic word in both byte orders; second word lands at address 1.
    send_word(8'h78, 8'h56, 8'h34, 8'h12);
    send_word(8'hC3, 8'h5A, 8'h0F, 8'hF0);

    // Framing error on the second byte, line held low as a break.
    pulse_start();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (3*CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2*CPB) @(negedge clk);
    check("le_frame_err", 64'(ferr_le), 64'(1));
    check("be_frame_err", 64'(ferr_be), 64'(1));
    check("le_busy_after_ferr", 64'(busy_le), 64'(0));
    send_word(8'h9E, 8'h37, 8'h79, 8'hB9);

    // Timeout drops a two-byte partial word.
    pulse_start();
    check("le_ferr_cleared", 64'(ferr_le), 64'(0));
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (2) @(negedge clk);
    check("le_busy_partial", 64'(busy_le), 64'(1));
    repeat (TO + 10) @(negedge clk);
    check("le_timeout_err", 64'(terr_le), 64'(1));
    check("be_timeout_err", 64'(terr_be), 64'(1));
    check("le_busy_timeout", 64'(busy_le), 64'(0));
    send_word(8'hAA, 8'hBB, 8'hCC, 8'hDD);

    // Address wrap on the 2-bit instance: 0,1,2,3,0.
    pulse_start();
    send_word(8'h10, 8'h11, 8'h12, 8'h13);
    send_word(8'h20, 8'h21, 8'h22, 8'h23);
    send_word(8'h30, 8'h31, 8'h32, 8'h33);
    send_word(8'h40, 8'h41, 8'h42, 8'h43);
    send_word(8'h50, 8'h51, 8'h52, 8'h53);
    check("le_wrapped_final", 64'(wrap_le), 64'(1));
    check("le_count_final", 64'(cnt_le), 64'(5));

    // start after three bytes discards them and clears all flags.
    send_byte(8'hE1, 1'b1);
    send_byte(8'hE2, 1'b1);
    send_byte(8'hE3, 1'b1);
    repeat (3) @(negedge clk);
    pulse_start();
    check("le_flags_after_start", 64'({ferr_le, terr_le, wrap_le, cnt_le}), 64'(0));
    send_word(8'h01, 8'h02, 8'h03, 8'h04);
    check("le_flags_clear", 64'({ferr_le, terr_le, wrap_le}), 64'(0));

    // Reset in the middle of a frame, then a clean word at address 0.
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    rx = 1'b0;
    repeat (3*CPB) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (2*CPB) @(negedge clk);
    send_word(8'h5D, 8'hC4, 8'hB7, 8'hA8);

    repeat (10) @(negedge clk);
    check("le_pending", 64'(q_le_d.size()), 64'(0));
    check("be_pending", 64'(q_be_d.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
